// File: rtl/delay_line_pipe.sv
// Enabled shift-register delay line with a selectable output tap and a
// registered count of valid stages.
module delay_line_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [DW-1:0]          dly,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [DW-1:0]          occ
);

    logic [WIDTH-1:0] stg [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_shift;
    logic [DW-1:0]    occ_q;
    logic [DW-1:0]    occ_shift;
    logic [DW-1:0]    sel;

    // Valid vector as it will look after a shift; occ is counted from this
    // so it lands on the same edge as v.
    always_comb begin
        v_shift    = '0;
        v_shift[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            v_shift[k] = v[k-1];
        end
    end

    always_comb begin
        occ_shift = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_shift = occ_shift + DW'(v_shift[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg[k] <= '0;
            end
            v     <= '0;
            occ_q <= '0;
        end else if (flush) begin
            v     <= '0;
            occ_q <= '0;
        end else if (en) begin
            stg[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                stg[k] <= stg[k-1];
            end
            v     <= v_shift;
            occ_q <= occ_shift;
        end
    end

    // Tap index is clamp(dly, 1, DEPTH) - 1.
    always_comb begin
        if (dly == '0) begin
            sel = '0;
        end else if (dly > DW'(DEPTH)) begin
            sel = DW'(DEPTH - 1);
        end else begin
            sel = dly - 1'b1;
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == DW'(k)) begin
                out_data  = stg[k];
                out_valid = v[k];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_taps
        assign taps[k*WIDTH +: WIDTH] = stg[k];
    end

    assign occ = occ_q;

endmodule

// File: tb/tb_delay_line_pipe.sv
// Directed bench for delay_line_pipe: an 8x4 instance for the main scenarios
// and a default-parameter instance for the 1-bit, 3-deep case.
module tb_delay_line_pipe;

    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid;
    logic [7:0]  in_data;
    logic [2:0]  dly;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [31:0] taps;
    logic [2:0]  occ;

    logic        b_rst, b_en, b_flush, b_in_valid;
    logic [0:0]  b_in_data;
    logic [1:0]  b_dly;
    logic        b_out_valid;
    logic [0:0]  b_out_data;
    logic [2:0]  b_taps;
    logic [1:0]  b_occ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_line_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .dly(dly), .out_valid(out_valid),
        .out_data(out_data), .taps(taps), .occ(occ)
    );

    delay_line_pipe dut_def (
        .clk(clk), .rst(b_rst), .en(b_en), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .dly(b_dly),
        .out_valid(b_out_valid), .out_data(b_out_data), .taps(b_taps),
        .occ(b_occ)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_data = 8'hA5; dly = 3'd3;
        step();
        rst = 1'b0; en = 1'b0; in_valid = 1'b0;
        checks++;
        if (taps !== 32'h0) begin
            failures++; $display("FAIL reset_taps got=%h exp=%h", taps, 32'h0);
        end
        checks++;
        if (occ !== 3'd0) begin
            failures++; $display("FAIL reset_occ got=%0d exp=0", occ);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%b/%h exp=0/00", out_valid, out_data);
        end
    endtask

    task automatic test_latency();
        logic [7:0] din   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] exp_d [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
        logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        dly = 3'd3; en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = din[i];
            step();
            checks++;
            if (occ !== 3'(i + 1)) begin
                failures++;
                $display("FAIL latency_occ edge=%0d got=%0d exp=%0d", i + 1, occ, i + 1);
            end
            checks++;
            if (out_valid !== exp_v[i] || out_data !== exp_d[i]) begin
                failures++;
                $display("FAIL latency_out edge=%0d got=%b/%h exp=%b/%h",
                         i + 1, out_valid, out_data, exp_v[i], exp_d[i]);
            end
        end
        checks++;
        if (taps !== 32'h11223344) begin
            failures++; $display("FAIL latency_taps got=%h exp=11223344", taps);
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        rst = 1'b1; step(); rst = 1'b0;
        dly = 3'd3; en = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        en = 1'b0; in_data = 8'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (taps !== 32'h00001122 || occ !== 3'd2) begin
                failures++;
                $display("FAIL stall_frozen cyc=%0d got=%h/%0d exp=00001122/2", i, taps, occ);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL stall_early_out got=%b exp=0", out_valid);
            end
        end
        en = 1'b1; in_data = 8'h33; step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || occ !== 3'd3) begin
            failures++;
            $display("FAIL stall_third_edge got=%b/%h/%0d exp=1/11/3", out_valid, out_data, occ);
        end
        in_data = 8'h44; step();
        en = 1'b0;
        checks++;
        if (occ !== 3'd4 || taps !== 32'h11223344) begin
            failures++; $display("FAIL stall_full got=%0d/%h exp=4/11223344", occ, taps);
        end
    endtask

    task automatic test_clamp();
        logic [2:0] dv   [5] = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd4};
        logic [7:0] expd [5] = '{8'h44, 8'h11, 8'h44, 8'h33, 8'h11};
        for (int i = 0; i < 5; i++) begin
            dly = dv[i];
            #1;
            checks++;
            if (out_data !== expd[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL clamp dly=%0d got=%b/%h exp=1/%h", dv[i], out_valid, out_data, expd[i]);
            end
        end
        dly = 3'd0; #1;
        checks++;
        if (out_data !== taps[7:0]) begin
            failures++; $display("FAIL clamp_tap0 got=%h exp=%h", out_data, taps[7:0]);
        end
        dly = 3'd7; #1;
        checks++;
        if (out_data !== taps[31:24]) begin
            failures++; $display("FAIL clamp_tap3 got=%h exp=%h", out_data, taps[31:24]);
        end
        dly = 3'd3;
    endtask

    task automatic test_flush();
        flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        step();
        flush = 1'b0; en = 1'b0;
        checks++;
        if (occ !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_valid got=%0d/%b exp=0/0", occ, out_valid);
        end
        checks++;
        if (taps !== 32'h11223344) begin
            failures++; $display("FAIL flush_taps got=%h exp=11223344", taps);
        end
        en = 1'b1; in_data = 8'h66; step(); en = 1'b0;
        checks++;
        if (occ !== 3'd1 || taps !== 32'h22334466) begin
            failures++; $display("FAIL flush_resume got=%0d/%h exp=1/22334466", occ, taps);
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        step();
        rst = 1'b0; flush = 1'b0; en = 1'b0; in_valid = 1'b0;
        checks++;
        if (taps !== 32'h0 || occ !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_priority got=%h/%0d/%b exp=0/0/0", taps, occ, out_valid);
        end
    endtask

    task automatic test_default_params();
        logic [0:0] d   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        b_rst = 1'b1; b_en = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
        b_in_data = 1'b0; b_dly = 2'd3;
        step();
        b_rst = 1'b0; b_en = 1'b1; b_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_data = d[i];
            step();
            checks++;
            if (i < 2) begin
                if (b_out_valid !== 1'b0) begin
                    failures++; $display("FAIL def_early edge=%0d got=%b exp=0", i + 1, b_out_valid);
                end
            end else if (b_out_valid !== 1'b1 || b_out_data !== d[i-2]) begin
                failures++;
                $display("FAIL def_delay edge=%0d got=%b/%b exp=1/%b", i + 1, b_out_valid, b_out_data, d[i-2]);
            end
        end
        checks++;
        if (b_occ !== 2'd3) begin
            failures++; $display("FAIL def_occ got=%0d exp=3", b_occ);
        end
        b_en = 1'b0;
    endtask

    initial begin
        b_rst = 1'b1; b_en = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
        b_in_data = 1'b0; b_dly = 2'd3;
        test_reset();
        test_latency();
        test_stall();
        test_clamp();
        test_flush();
        test_reset_priority();
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
